hazard_ctrl: RTL and testbench

// Pipeline sequencer for the 5-stage RV32I core: owns every stall, flush and forwarding decision for the F/D, D/E and E/M registers.

---
 rtl/core_pkg.sv | 27 ++
 rtl/fwd_unit.sv | 23 ++
 rtl/hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-control types: forwarding source select, hazard FSM states
// and the register-match helper used by the hazard and forwarding logic.
package core_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  // True when an enabled, non-x0 destination matches a source register.
  function automatic logic reg_hit(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs,
                                   input logic             en);
    return en && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ALU operand in E; the younger M result
// takes precedence over the W result.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic             i_reg_write_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_reg_write_w,
  output logic [1:0]       o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (reg_hit(i_rd_m, i_rs, i_reg_write_m)) begin
      o_fwd = FWD_MEM;
    end else if (reg_hit(i_rd_w, i_rs, i_reg_write_w)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: stall/flush/redirect/forwarding
// decisions, data-memory wait FSM with watchdog, and saturating perf counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] i_rs1_d,
  input  logic [REG_W-1:0] i_rs2_d,
  input  logic             i_use_rs1_d,
  input  logic             i_use_rs2_d,
  input  logic [REG_W-1:0] i_rs_e1,
  input  logic [REG_W-1:0] i_rs_e2,
  input  logic [REG_W-1:0] i_rd_e,
  input  logic             i_load_e,
  input  logic             i_branch_result_e,
  input  logic             i_jump_e,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_reg_write_m,
  input  logic             i_reg_write_w,
  input  logic             i_dmem_req_m,
  input  logic             i_dmem_ready_m,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_stall_e,
  output logic             o_stall_m,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic             o_pc_redirect,
  output logic [1:0]       o_fwd_a_e,
  output logic [1:0]       o_fwd_b_e,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  hz_state_t        r_state;
  hz_state_t        w_next_state;
  logic             w_freeze;
  logic             w_lu;
  logic             w_redir;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  fwd_unit u_fwd_a (
    .i_rs          (i_rs_e1),
    .i_rd_m        (i_rd_m),
    .i_reg_write_m (i_reg_write_m),
    .i_rd_w        (i_rd_w),
    .i_reg_write_w (i_reg_write_w),
    .o_fwd         (w_fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_rs          (i_rs_e2),
    .i_rd_m        (i_rd_m),
    .i_reg_write_m (i_reg_write_m),
    .i_rd_w        (i_rd_w),
    .i_reg_write_w (i_reg_write_w),
    .o_fwd         (w_fwd_b)
  );

  assign w_lu    = i_load_e && (reg_hit(i_rd_e, i_rs1_d, i_use_rs1_d) ||
                                reg_hit(i_rd_e, i_rs2_d, i_use_rs2_d));
  assign w_redir = i_branch_result_e || i_jump_e;

  // Reset forces every control output low, independent of the inputs.
  assign o_fwd_a_e = rst ? 2'(FWD_RF) : w_fwd_a;
  assign o_fwd_b_e = rst ? 2'(FWD_RF) : w_fwd_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and control outputs; freeze > redirect > load-use.
  always_comb begin
    w_next_state  = r_state;
    w_freeze      = 1'b0;
    o_stall_f     = 1'b0;
    o_stall_d     = 1'b0;
    o_stall_e     = 1'b0;
    o_stall_m     = 1'b0;
    o_flush_d     = 1'b0;
    o_flush_e     = 1'b0;
    o_pc_redirect = 1'b0;
    case (r_state)
      RUN: begin
        if (i_dmem_req_m && !i_dmem_ready_m) begin
          w_next_state = MEM_WAIT;
          w_freeze     = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (i_dmem_ready_m) begin
          w_next_state = RUN;
        end else begin
          w_freeze = 1'b1;
        end
      end
      default: w_next_state = RUN;
    endcase
    if (w_freeze) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_stall_e = 1'b1;
      o_stall_m = 1'b1;
    end else if (w_redir) begin
      o_pc_redirect = 1'b1;
      o_flush_d     = 1'b1;
      o_flush_e     = 1'b1;
    end else if (w_lu) begin
      o_stall_f = 1'b1;
      o_stall_d = 1'b1;
      o_flush_e = 1'b1;
    end
    if (rst) begin
      o_stall_f     = 1'b0;
      o_stall_d     = 1'b0;
      o_stall_e     = 1'b0;
      o_stall_m     = 1'b0;
      o_flush_d     = 1'b0;
      o_flush_e     = 1'b0;
      o_pc_redirect = 1'b0;
    end
  end

  // Watchdog counts consecutive frozen cycles, including the entry cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt      <= '0;
      r_mem_timeout <= 1'b0;
    end else if (w_freeze) begin
      if (r_wd_cnt != WD_W'(TIMEOUT)) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
        r_mem_timeout <= 1'b1;
      end
    end else begin
      r_wd_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall_f && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (o_pc_redirect && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_mem_timeout = r_mem_timeout;
  assign o_stall_cnt   = r_stall_cnt;
  assign o_flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect, memory wait,
// watchdog, async reset and counter saturation.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [4:0]       rs1_d, rs2_d, rs_e1, rs_e2, rd_e, rd_m, rd_w;
  logic             use_rs1_d, use_rs2_d, load_e, branch_e, jump_e;
  logic             reg_write_m, reg_write_w, dmem_req_m, dmem_ready_m;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, pc_redirect, mem_timeout;
  logic [1:0]       fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       ctl;

  int total = 0;
  int bad   = 0;

  // {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_redirect}
  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, pc_redirect};

  hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_rs1_d           (rs1_d),
    .i_rs2_d           (rs2_d),
    .i_use_rs1_d       (use_rs1_d),
    .i_use_rs2_d       (use_rs2_d),
    .i_rs_e1           (rs_e1),
    .i_rs_e2           (rs_e2),
    .i_rd_e            (rd_e),
    .i_load_e          (load_e),
    .i_branch_result_e (branch_e),
    .i_jump_e          (jump_e),
    .i_rd_m            (rd_m),
    .i_rd_w            (rd_w),
    .i_reg_write_m     (reg_write_m),
    .i_reg_write_w     (reg_write_w),
    .i_dmem_req_m      (dmem_req_m),
    .i_dmem_ready_m    (dmem_ready_m),
    .o_stall_f         (stall_f),
    .o_stall_d         (stall_d),
    .o_stall_e         (stall_e),
    .o_stall_m         (stall_m),
    .o_flush_d         (flush_d),
    .o_flush_e         (flush_e),
    .o_pc_redirect     (pc_redirect),
    .o_fwd_a_e         (fwd_a_e),
    .o_fwd_b_e         (fwd_b_e),
    .o_mem_timeout     (mem_timeout),
    .o_stall_cnt       (stall_cnt),
    .o_flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    rs1_d = '0; rs2_d = '0; rs_e1 = '0; rs_e2 = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    use_rs1_d = 0; use_rs2_d = 0; load_e = 0; branch_e = 0; jump_e = 0;
    reg_write_m = 0; reg_write_w = 0; dmem_req_m = 0; dmem_ready_m = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    dmem_req_m = 1; branch_e = 1;
    @(negedge clk);
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0); end
    total++; if (fwd_a_e !== 2'b00 || fwd_b_e !== 2'b00) begin bad++; $display("FAIL reset_fwd got=%b/%b exp=00/00", fwd_a_e, fwd_b_e); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
    idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    rd_m = 5'd3; reg_write_m = 1; rd_w = 5'd3; reg_write_w = 1; rs_e1 = 5'd3;
    #1;
    total++; if (fwd_a_e !== 2'b10) begin bad++; $display("FAIL fwd_m_over_w got=%b exp=10", fwd_a_e); end
    rd_m = 5'd0;
    #1;
    total++; if (fwd_a_e !== 2'b01) begin bad++; $display("FAIL fwd_w got=%b exp=01", fwd_a_e); end
    rd_w = 5'd0; rs_e1 = 5'd0;
    #1;
    total++; if (fwd_a_e !== 2'b00) begin bad++; $display("FAIL fwd_x0 got=%b exp=00", fwd_a_e); end
    rs_e2 = 5'd7; rd_m = 5'd7; reg_write_m = 0; rd_w = 5'd7; reg_write_w = 1;
    #1;
    total++; if (fwd_b_e !== 2'b01 || fwd_a_e !== 2'b00) begin bad++; $display("FAIL fwd_b_w got=%b/%b exp=00/01", fwd_a_e, fwd_b_e); end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    load_e = 1; rd_e = 5'd5; rs2_d = 5'd5; use_rs2_d = 1;
    #1;
    total++; if (ctl !== 7'b1100010) begin bad++; $display("FAIL lu_ctl got=%b exp=%b", ctl, 7'b1100010); end
    @(negedge clk);
    idle();
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lu_release got=%b exp=%b", ctl, 7'b0); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    load_e = 1; rd_e = 5'd0; rs1_d = 5'd0; use_rs1_d = 1;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lu_x0 got=%b exp=%b", ctl, 7'b0); end
    rd_e = 5'd5; rs2_d = 5'd5; use_rs2_d = 0; rs1_d = 5'd4;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL lu_unused_rs got=%b exp=%b", ctl, 7'b0); end
    @(negedge clk);
    idle();
    #1;
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_stall_cnt_hold got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    load_e = 1; rd_e = 5'd5; rs2_d = 5'd5; use_rs2_d = 1; branch_e = 1;
    #1;
    total++; if (ctl !== 7'b0000111) begin bad++; $display("FAIL redir_over_lu got=%b exp=%b", ctl, 7'b0000111); end
    @(negedge clk);
    idle();
    #1;
    total++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin bad++; $display("FAIL redir_cnt got=%0d/%0d exp=1/1", flush_cnt, stall_cnt); end
    jump_e = 1;
    #1;
    total++; if (ctl !== 7'b0000111) begin bad++; $display("FAIL jump_ctl got=%b exp=%b", ctl, 7'b0000111); end
    @(negedge clk);
    idle();
    #1;
    total++; if (flush_cnt !== 16'd2) begin bad++; $display("FAIL jump_cnt got=%0d exp=2", flush_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    @(negedge clk);
    dmem_req_m = 1; dmem_ready_m = 0; branch_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== 7'b1111000) begin bad++; $display("FAIL wait_ctl cyc=%0d got=%b exp=%b", i, ctl, 7'b1111000); end
      @(negedge clk);
    end
    dmem_ready_m = 1;
    #1;
    total++; if (ctl !== 7'b0000111) begin bad++; $display("FAIL wait_exit got=%b exp=%b", ctl, 7'b0000111); end
    @(negedge clk);
    idle();
    #1;
    total++; if (stall_cnt !== 16'd3 || flush_cnt !== 16'd1) begin bad++; $display("FAIL wait_cnt got=%0d/%0d exp=3/1", stall_cnt, flush_cnt); end
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL wait_timeout got=%b exp=0", mem_timeout); end
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL wait_run got=%b exp=%b", ctl, 7'b0); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    dmem_req_m = 1; dmem_ready_m = 0;
    repeat (63) @(negedge clk);
    #1;
    total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early got=%b exp=0", mem_timeout); end
    @(negedge clk);
    #1;
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_set got=%b exp=1", mem_timeout); end
    dmem_ready_m = 1;
    @(negedge clk);
    idle();
    @(negedge clk);
    #1;
    total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", mem_timeout); end
    dmem_req_m = 1; dmem_ready_m = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL async_rst_ctl got=%b exp=%b", ctl, 7'b0); end
    total++; if (mem_timeout !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL async_rst_regs got=%b/%0d exp=0/0", mem_timeout, stall_cnt); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (ctl !== 7'b0) begin bad++; $display("FAIL rst_to_run got=%b exp=%b", ctl, 7'b0); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    dmem_req_m = 1; dmem_ready_m = 0;
    repeat ((1 << CNT_W) + 5) @(negedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL stall_sat got=%h exp=ffff", stall_cnt); end
    total++; if (flush_cnt !== 16'd0) begin bad++; $display("FAIL sat_flush got=%0d exp=0", flush_cnt); end
    dmem_ready_m = 1;
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
